// File: rtl/mem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_fetch_unit
// Brief    : Sequential instruction fetcher sitting behind a single-cycle
//            synchronous-read memory. Words are buffered in a small FIFO and
//            delivered over valid/ready. It survives the programming
//            controller stealing the memory, and PC redirects flush it.
// Revision : 1.0 - initial release
// ============================================================================
module mem_fetch_unit #(
  parameter int          MEM_ADDR_WIDTH = 10,
  parameter int          MEM_DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH     = 4,
  parameter int unsigned RESET_ADDR     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  input  logic [MEM_DATA_WIDTH-1:0]     mem_rdata,
  input  logic                          mem_busy,
  input  logic                          redirect_valid,
  input  logic [MEM_ADDR_WIDTH-1:0]     redirect_addr,
  output logic                          instr_valid,
  output logic [MEM_DATA_WIDTH-1:0]     instr_data,
  output logic [MEM_ADDR_WIDTH-1:0]     instr_addr,
  input  logic                          instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_CRD_W = c_LVL_W + 1;

  logic [MEM_ADDR_WIDTH-1:0] r_pc;
  logic                      r_inflight;
  logic [MEM_ADDR_WIDTH-1:0] r_inflight_addr;
  logic [MEM_DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [MEM_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_LVL_W-1:0]        r_count;

  logic                      w_pop;
  logic                      w_issue;
  logic                      w_capture;
  logic                      w_push;
  logic                      w_discard;
  logic [c_CRD_W-1:0]        w_credit;

  // Handshake, credit and capture decisions for the current cycle.
  always_comb begin
    instr_valid = (r_count != '0);
    w_pop       = instr_valid & instr_ready;
    // Entries that will still be occupied or owed after this cycle's pop;
    // never negative because a pop implies at least one entry.
    w_credit    = c_CRD_W'(r_count) + c_CRD_W'(r_inflight) - c_CRD_W'(w_pop);
    w_issue     = !mem_busy && !redirect_valid && (w_credit < c_CRD_W'(FIFO_DEPTH));
    w_capture   = r_inflight & !redirect_valid;
    // Memory output is forced to zero while busy, so that word must be refetched.
    w_push      = w_capture & !mem_busy;
    w_discard   = w_capture & mem_busy;
  end

  // Head of FIFO is masked while empty so outputs read zero straight out of reset.
  always_comb begin
    mem_addr   = r_pc;
    fifo_level = r_count;
    instr_data = instr_valid ? r_fifo_data[r_rd_ptr] : '0;
    instr_addr = instr_valid ? r_fifo_addr[r_rd_ptr] : '0;
  end

  // Fetch pointer, in-flight tracking and FIFO bookkeeping; redirect wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= MEM_ADDR_WIDTH'(RESET_ADDR);
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_addr;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_discard) begin
        r_pc <= r_inflight_addr;
      end else if (w_issue) begin
        r_pc <= r_pc + MEM_ADDR_WIDTH'(1);
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_pc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= r_count + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
    end
  end

  // FIFO storage; contents need no reset since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_rdata;
      r_fifo_addr[r_wr_ptr] <= r_inflight_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_fetch_unit
// Brief    : Self-checking bench for mem_fetch_unit with a behavioural memory
//            and an in-order stream model of the expected instruction flow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_fetch_unit;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_addr;
  logic          instr_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;

  mem_fetch_unit #(
    .MEM_ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(DW),
    .FIFO_DEPTH    (DEPTH),
    .RESET_ADDR    (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_busy      (mem_busy),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_addr    (instr_addr),
    .instr_ready   (instr_ready),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Memory: one-cycle synchronous read, output forced to zero while busy.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) rdata_q <= mem[mem_addr];
  assign mem_rdata = mem_busy ? '0 : rdata_q;

  int checks = 0;
  int errors = 0;

  // Stream model: the consumer must see consecutive addresses from the last
  // restart point, each carrying that address's memory word.
  logic [AW-1:0] exp_addr = '0;
  logic          prev_hold = 1'b0;
  logic          prev_redir = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  int            pops = 0;

  // Per-cycle samples for the hand-computed expectations.
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [$clog2(DEPTH):0] s_level;
  logic [AW-1:0] s_mem_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    s_valid    = instr_valid;
    s_addr     = instr_addr;
    s_data     = instr_data;
    s_level    = fifo_level;
    s_mem_addr = mem_addr;
    if (!rst_n) begin
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_data", 64'(instr_data), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      exp_addr   = '0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) check("valid_after_redirect", 64'(instr_valid), 64'd0);
      if (prev_hold) begin
        check("hold_valid", 64'(instr_valid), 64'd1);
        check("hold_addr", 64'(instr_addr), 64'(prev_addr));
        check("hold_data", 64'(instr_data), 64'(prev_data));
      end
      check("level_bound", 64'(fifo_level <= DEPTH), 64'd1);
      if (instr_valid && instr_ready) begin
        check("pop_addr", 64'(instr_addr), 64'(exp_addr));
        check("pop_data", 64'(instr_data), 64'(mem[exp_addr]));
        pops++;
        exp_addr = exp_addr + 1'b1;
      end
      if (redirect_valid) exp_addr = redirect_addr;
      prev_redir = redirect_valid;
      prev_hold  = instr_valid & !instr_ready & !redirect_valid;
      prev_addr  = instr_addr;
      prev_data  = instr_data;
    end
  endtask

  // One clock: sample/check at the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    mem_busy       = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int target;
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA0 + i;

    // A: latency from reset release and the initial stream.
    instr_ready = 1'b1;
    do_reset();
    cycle(); check("A_c0_valid", 64'(s_valid), 64'd0);
    cycle(); check("A_c1_valid", 64'(s_valid), 64'd0);
    cycle(); check("A_c2_valid", 64'(s_valid), 64'd1);
    check("A_c2_addr", 64'(s_addr), 64'h0);
    check("A_c2_data", 64'(s_data), 64'hA0);
    cycle(); check("A_c3_addr", 64'(s_addr), 64'h1);
    check("A_c3_data", 64'(s_data), 64'hA1);
    cycle(); check("A_c4_addr", 64'(s_addr), 64'h2);

    // B: back-pressure fills the FIFO, then drain with no gap; C: busy
    // during the capture of word 5 must not produce a zero or a gap.
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) cycle();
    check("B_level_full", 64'(s_level), 64'd4);
    check("B_mem_addr", 64'(s_mem_addr), 64'd4);
    check("B_head_addr", 64'(s_addr), 64'd0);
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem_busy = (k == 2);
      cycle();
      check("BC_valid", 64'(s_valid), 64'd1);
      check("BC_addr", 64'(s_addr), 64'(k));
      check("BC_data", 64'(s_data), 64'(32'hA0 + k));
    end
    mem_busy = 1'b0;

    // C2: longer busy window; buffered words drain and fetch resumes.
    mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    mem_busy = 1'b0;
    target = pops + 3;
    n = 0;
    while (pops < target && n < 20) begin
      cycle();
      n++;
    end
    check("C2_resume_after_busy", 64'(pops >= target), 64'd1);

    // D: redirect to 0x3FE with three buffered entries, then wrap.
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 10'h3FE;
    cycle();
    check("D_level_at_redirect", 64'(s_level), 64'd3);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    cycle(); check("D_r1_valid", 64'(s_valid), 64'd0);
    cycle(); check("D_r2_valid", 64'(s_valid), 64'd0);
    cycle(); check("D_r3_addr", 64'(s_addr), 64'h3FE);
    check("D_r3_data", 64'(s_data), 64'h49E);
    check("D_r3_valid", 64'(s_valid), 64'd1);
    cycle(); check("D_r4_addr", 64'(s_addr), 64'h3FF);
    cycle(); check("D_r5_addr", 64'(s_addr), 64'h000);
    check("D_r5_data", 64'(s_data), 64'hA0);

    // E: redirect coinciding with a pop of word 4.
    cycle(); cycle(); cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 10'h100;
    cycle();
    check("E_popped_addr", 64'(s_addr), 64'h4);
    redirect_valid = 1'b0;
    cycle(); check("E_r1_valid", 64'(s_valid), 64'd0);
    cycle(); check("E_r2_valid", 64'(s_valid), 64'd0);
    cycle(); check("E_r3_addr", 64'(s_addr), 64'h100);
    check("E_r3_data", 64'(s_data), 64'h1A0);
    cycle(); check("E_r4_addr", 64'(s_addr), 64'h101);

    // F: asynchronous reset mid-stream with a non-empty FIFO.
    instr_ready = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    check("F_valid_before", 64'(s_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("F_async_valid", 64'(instr_valid), 64'd0);
    check("F_async_level", 64'(fifo_level), 64'd0);
    check("F_async_data", 64'(instr_data), 64'd0);
    check("F_async_addr", 64'(instr_addr), 64'd0);
    check("F_async_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #1;
    cycle();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("F_restart_addr", 64'(s_addr), 64'h0);
    check("F_restart_valid", 64'(s_valid), 64'd1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_fetch_unit.md
# mem_fetch_unit

Sequential instruction fetcher that sits directly downstream of the memory top level. It drives the `in_address` port and consumes `out_data` under the memory's one-cycle synchronous read latency. Fetched words are buffered in a small FIFO and handed to the CPU core over a valid/ready handshake. It tolerates the programming controller taking the memory mid-stream and supports PC redirects that flush all buffered and in-flight words.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, default 10: word-address width, matching the memory.
- `MEM_DATA_WIDTH`, default 32: word width.
- `FIFO_DEPTH`, default 4: instruction buffer entries; power of two, at least 2.
- `RESET_ADDR`, default 0: first fetch address after reset.

Ports (clock and reset first):
- `clk`  in  1: single clock for all logic.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `mem_addr`  out  MEM_ADDR_WIDTH: read address; connects to the memory `in_address`.
- `mem_rdata`  in  MEM_DATA_WIDTH: read data; connects to `out_data`. Valid one cycle after the address.
- `mem_busy`  in  1: memory owned by the programming controller (`mem_control_enable`).
- `redirect_valid`  in  1: one-cycle request to restart fetch at a new address.
- `redirect_addr`  in  MEM_ADDR_WIDTH: restart address.
- `instr_valid`  out  1: FIFO head is valid.
- `instr_data`  out  MEM_DATA_WIDTH: FIFO head word.
- `instr_addr`  out  MEM_ADDR_WIDTH: word address of the FIFO head.
- `instr_ready`  in  1: consumer accepts the head.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: occupied entries.

## Operation
Registers:
- `pc`: next address to fetch.
- In-flight flag and in-flight address: one outstanding read at most.
- FIFO storing {data, addr} pairs, with read/write pointers and a count.

Datapath:
- `mem_addr` = `pc` combinationally at all times.
- Pop occurs when `instr_valid & instr_ready`.

Issue condition in a cycle: `!mem_busy & !redirect_valid & (level + inflight - pop < FIFO_DEPTH)`.
- On issue: set in-flight flag, record addr = `pc`, and set `pc <= pc + 1` (wraps modulo 2^MEM_ADDR_WIDTH; `2^AW-1` is followed by 0).

Capture cycle (in-flight set, no redirect):
- If `mem_busy = 0`: write {`mem_rdata`, inflight addr} into the FIFO.
- If `mem_busy = 1`: the data is masked to zero, so discard it and set `pc <= inflight addr` to refetch. This overrides the +1 from any issue, and no issue is possible this cycle anyway.

Redirect (highest priority):
- A pop in the same cycle still counts as accepted by the consumer.
- The FIFO is then emptied and the in-flight read killed.
- `pc <= redirect_addr`; no issue in the redirect cycle.

Credit rule: level plus in-flight never exceeds `FIFO_DEPTH`, so a capture never finds the FIFO full.

## Timing
Reset values:
- `instr_valid` = 0; `instr_data` = 0; `instr_addr` = 0; `fifo_level` = 0.
- `pc` = `RESET_ADDR`, so `mem_addr` = `RESET_ADDR`; in-flight flag = 0.

Latency:
- Issue in cycle N, capture in N+1, `instr_valid` high in N+2. There is no bypass.
- After reset release: first issue on the first clock edge; first `instr_valid` two cycles later.
- Redirect asserted in cycle R:
  - `instr_valid` = 0 from R+1.
  - Issue of `redirect_addr` in R+1; `instr_valid` with that address in R+3.
- Sustained throughput is 1 word/cycle with `instr_ready` held high and `mem_busy` low, for any `FIFO_DEPTH` of at least 2.

Handshake and control:
- `instr_data`/`instr_addr` stay stable while `instr_valid & !instr_ready`.
- `mem_busy` high blocks new issues for its duration. Buffered entries remain poppable, and fetch resumes at the correct address on the first cycle `mem_busy` is low.

Simultaneous and reset events:
- Push and pop in the same cycle leave `fifo_level` unchanged.
- Redirect and a `mem_busy` discard in the same cycle: redirect wins.
- `rst_n` low mid-operation clears all state immediately (asynchronously); outputs return to reset values without waiting for a clock.

## Test plan
- Reset, memory words 0..7 preloaded with `0xA0+i`, `instr_ready`=1 -> `instr_valid` rises 2 cycles after reset release; `instr_addr` 0,1,2,… each cycle with data `0xA0`,`0xA1`,…
- `instr_ready`=0 for 10 cycles -> `fifo_level` saturates at 4; `mem_addr` stops at 4; exactly 4 reads issued. Raising ready -> words 0..3 then 4 follow with no gap or duplicate.
- `mem_busy` pulsed high during the capture of addr 5 -> word 5 is discarded and refetched. The output sequence is 4,5,6 with the correct data, no zero word.
- `redirect_valid` with `redirect_addr`=`0x3FE` while the FIFO holds 3 entries -> `instr_valid` = 0 next cycle; first output `0x3FE` 3 cycles after the redirect, then `0x3FF`, then `0x000` (wrap).
- Redirect coinciding with a pop -> the popped word counts as consumed, the remaining entries are flushed, and no stale address appears after the redirect.
- `rst_n` asserted mid-stream with the FIFO non-empty -> `instr_valid`, `fifo_level` and `instr_data` go to 0 before the next clock edge, and `mem_addr` = `RESET_ADDR`.
